// File: rtl/decode_stage_if.sv
// Decode-stage handshake, fetch inputs, register-file read port and decoded results.
// is_muldiv exists only when DECODE_M_EXT_EN is defined.
interface decode_stage_if #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned REG_ADDR_W = 5
);
   logic                  enabled;
   logic [XLEN-1:0]       pc;
   logic [XLEN-1:0]       instr_raw;
   logic                  is_jump_predicted;
   logic [XLEN-1:0]       next_pc;
   logic [REG_ADDR_W-1:0] rf_rs1_addr;
   logic [REG_ADDR_W-1:0] rf_rs2_addr;
   logic [XLEN-1:0]       rf_rs1_data;
   logic [XLEN-1:0]       rf_rs2_data;
   logic                  completed;
   logic [XLEN-1:0]       pc_d;
   logic [2:0]            instr_type;
   logic [REG_ADDR_W-1:0] rd;
   logic [REG_ADDR_W-1:0] rs1;
   logic [REG_ADDR_W-1:0] rs2;
   logic [XLEN-1:0]       imm;
   logic                  writes_rd;
   logic [XLEN-1:0]       rs1_val;
   logic [XLEN-1:0]       rs2_val;
   logic                  is_jump_predicted_d;
   logic [XLEN-1:0]       next_pc_d;
   logic                  illegal;
`ifdef DECODE_M_EXT_EN
   logic                  is_muldiv;
`endif

   modport master (
`ifdef DECODE_M_EXT_EN
      input  is_muldiv,
`endif
      output enabled, pc, instr_raw, is_jump_predicted, next_pc,
      output rf_rs1_data, rf_rs2_data,
      input  rf_rs1_addr, rf_rs2_addr,
      input  completed, pc_d, instr_type, rd, rs1, rs2, imm, writes_rd,
      input  rs1_val, rs2_val, is_jump_predicted_d, next_pc_d, illegal
   );

   modport slave (
`ifdef DECODE_M_EXT_EN
      output is_muldiv,
`endif
      input  enabled, pc, instr_raw, is_jump_predicted, next_pc,
      input  rf_rs1_data, rf_rs2_data,
      output rf_rs1_addr, rf_rs2_addr,
      output completed, pc_d, instr_type, rd, rs1, rs2, imm, writes_rd,
      output rs1_val, rs2_val, is_jump_predicted_d, next_pc_d, illegal
   );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: field/immediate extraction plus synchronous register-file read.
// Optional M-extension decode (is_muldiv) enabled by defining DECODE_M_EXT_EN.
module decode_stage #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned REG_ADDR_W = 5
) (
   input logic           clk,
   input logic           rst,
   decode_stage_if.slave bus
);
   typedef enum logic [1:0] {IDLE, REQ, CAP, DONE} state_t;
   typedef enum logic [2:0] {
      T_R   = 3'd0,
      T_I   = 3'd1,
      T_S   = 3'd2,
      T_B   = 3'd3,
      T_U   = 3'd4,
      T_J   = 3'd5,
      T_ILL = 3'd7
   } itype_t;

   state_t state, state_nx;
   logic   dec_load, cap_load;

   logic [XLEN-1:0] instr_q, pc_q, npc_q;
   logic            jp_q;
   logic            done_q;

   logic [6:0]            opcode, funct7;
   logic [REG_ADDR_W-1:0] f_rd, f_rs1, f_rs2;
   logic                  sgn;

   itype_t          dec_type;
   logic [XLEN-1:0] dec_imm;
   logic            dec_wr;

   itype_t                type_q;
   logic [REG_ADDR_W-1:0] rd_q, rs1_q, rs2_q;
   logic [XLEN-1:0]       imm_q, rs1_val_q, rs2_val_q;
   logic                  wr_q, ill_q;

`ifdef DECODE_M_EXT_EN
   logic dec_muldiv, muldiv_q;
`endif

   assign opcode = instr_q[6:0];
   assign funct7 = instr_q[31:25];
   assign f_rd   = instr_q[11:7];
   assign f_rs1  = instr_q[19:15];
   assign f_rs2  = instr_q[24:20];
   assign sgn    = instr_q[31];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // enabled wins in every state, so a new request aborts the one in flight
   always_comb begin
      state_nx = state;
      dec_load = 1'b0;
      cap_load = 1'b0;
      if (bus.enabled) begin
         state_nx = REQ;
      end else begin
         case (state)
            REQ: begin
               state_nx = CAP;
               dec_load = 1'b1;
            end
            CAP: begin
               state_nx = DONE;
               cap_load = 1'b1;
            end
            default: state_nx = state;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_q <= '0;
         pc_q    <= '0;
         npc_q   <= '0;
         jp_q    <= 1'b0;
      end else if (bus.enabled) begin
         instr_q <= bus.instr_raw;
         pc_q    <= bus.pc;
         npc_q   <= bus.next_pc;
         jp_q    <= bus.is_jump_predicted;
      end
   end

   always_comb begin
      dec_type = T_ILL;
      dec_imm  = '0;
`ifdef DECODE_M_EXT_EN
      dec_muldiv = 1'b0;
`endif
      case (opcode)
         7'b0110011: begin
`ifdef DECODE_M_EXT_EN
            dec_type   = T_R;
            dec_muldiv = (funct7 == 7'b0000001);
`else
            if (funct7 != 7'b0000001) dec_type = T_R;
`endif
         end
         7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: dec_type = T_I;
         7'b0100011:                                     dec_type = T_S;
         7'b1100011:                                     dec_type = T_B;
         7'b0110111, 7'b0010111:                         dec_type = T_U;
         7'b1101111:                                     dec_type = T_J;
         default:                                        dec_type = T_ILL;
      endcase

      case (dec_type)
         T_I: dec_imm = {{(XLEN-12){sgn}}, instr_q[31:20]};
         T_S: dec_imm = {{(XLEN-12){sgn}}, instr_q[31:25], instr_q[11:7]};
         T_B: dec_imm = {{(XLEN-13){sgn}}, instr_q[31], instr_q[7],
                         instr_q[30:25], instr_q[11:8], 1'b0};
         T_U: dec_imm = {instr_q[31:12], 12'b0};
         T_J: dec_imm = {{(XLEN-21){sgn}}, instr_q[31], instr_q[19:12],
                         instr_q[20], instr_q[30:21], 1'b0};
         default: dec_imm = '0;
      endcase

      dec_wr = (dec_type inside {T_R, T_I, T_U, T_J}) && (f_rd != '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         type_q <= T_ILL;
         rd_q   <= '0;
         rs1_q  <= '0;
         rs2_q  <= '0;
         imm_q  <= '0;
         wr_q   <= 1'b0;
         ill_q  <= 1'b0;
      end else if (dec_load) begin
         type_q <= dec_type;
         rd_q   <= f_rd;
         rs1_q  <= f_rs1;
         rs2_q  <= f_rs2;
         imm_q  <= dec_imm;
         wr_q   <= dec_wr;
         ill_q  <= (dec_type == T_ILL);
      end
   end

`ifdef DECODE_M_EXT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           muldiv_q <= 1'b0;
      else if (dec_load) muldiv_q <= dec_muldiv;
   end
   assign bus.is_muldiv = muldiv_q;
`endif

   // x0 reads as zero regardless of what the register file returns
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rs1_val_q <= '0;
         rs2_val_q <= '0;
      end else if (cap_load) begin
         rs1_val_q <= (f_rs1 == '0) ? '0 : bus.rf_rs1_data;
         rs2_val_q <= (f_rs2 == '0) ? '0 : bus.rf_rs2_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)              done_q <= 1'b0;
      else if (bus.enabled) done_q <= 1'b0;
      else if (cap_load)    done_q <= 1'b1;
   end

   assign bus.rf_rs1_addr         = f_rs1;
   assign bus.rf_rs2_addr         = f_rs2;
   assign bus.completed           = done_q & ~bus.enabled;
   assign bus.pc_d                = pc_q;
   assign bus.next_pc_d           = npc_q;
   assign bus.is_jump_predicted_d = jp_q;
   assign bus.instr_type          = type_q;
   assign bus.rd                  = rd_q;
   assign bus.rs1                 = rs1_q;
   assign bus.rs2                 = rs2_q;
   assign bus.imm                 = imm_q;
   assign bus.writes_rd           = wr_q;
   assign bus.illegal             = ill_q;
   assign bus.rs1_val             = rs1_val_q;
   assign bus.rs2_val             = rs2_val_q;
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Second pipeline stage of the RV32I core; sits directly downstream of the fetch stage.
- Consumes the fetched instruction word, its PC and the branch-prediction result.
- Extracts register indices, instruction format and sign-extended immediate, then performs a synchronous register-file read.
- Uses the same enabled/completed handshake as the other stages so the core controller sequences it identically.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- enabled  input  1  start pulse from the controller; latches the inputs below
- pc  input  32  PC of the instruction (fetch pc_n)
- instr_raw  input  32  instruction word from fetch
- is_jump_predicted  input  1  prediction flag from fetch
- next_pc  input  32  predicted next PC from fetch
- rf_rs1_addr  output  5  register-file read address A
- rf_rs2_addr  output  5  register-file read address B
- rf_rs1_data  input  32  register-file data A; valid one cycle after the address
- rf_rs2_data  input  32  register-file data B; valid one cycle after the address
- completed  output  1  results valid
- pc_d  output  32  latched PC
- instr_type  output  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal
- rd, rs1, rs2  output  5 each  register fields
- imm  output  32  sign-extended immediate
- writes_rd  output  1  instruction writes rd and rd is not 0
- rs1_val, rs2_val  output  32 each  operand values
- is_jump_predicted_d, next_pc_d  output  1/32  pass-through of the prediction
- illegal  output  1  opcode not recognised

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE.
  - All outputs 0, except instr_type=7.
  - Reset takes effect mid-operation with no partial update surviving.
- States: IDLE, REQ, CAP, DONE.
- On any edge with enabled=1, regardless of state (this aborts an operation in progress):
  - Latch pc, instr_raw, is_jump_predicted and next_pc.
  - Clear internal done flag.
  - Go to REQ.
- REQ:
  - rf_rs1_addr/rf_rs2_addr driven from the latched instr[19:15]/[24:20].
  - Decoded fields are computed combinationally from the latched word and registered at the end of REQ.
  - Next state: CAP.
- CAP:
  - Capture rf_rs1_data/rf_rs2_data into rs1_val/rs2_val.
  - A value is forced to 0 when its index is 0.
  - Set done flag. Next state: DONE.
- DONE: hold all outputs until the next enabled.
- completed = done & !enabled.
  - Rises after the second edge following the edge at which enabled was sampled.
  - Drops combinationally on enabled.
- Opcode map:
  - 0110011 R
  - 0010011, 0000011, 1100111, 1110011 I
  - 0100011 S
  - 1100011 B
  - 0110111, 0010111 U
  - 1101111 J
  - anything else illegal=1, instr_type=7.
- Immediates per RV32I, sign bit instr[31]:
  - I: [31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - U: {[31:12],12'b0}
  - J: {[31],[19:12],[20],[30:21],0}
  - R and illegal: imm=0.
- writes_rd=1 for R, I, U and J types when rd is not 0; 0 for S, B and illegal.
- For an illegal instruction the register fields are still extracted, but writes_rd=0.
- Address outputs remain stable from REQ through DONE.

Optional Feature:
- Macro DECODE_M_EXT_EN.
- Defined:
  - opcode 0110011 with funct7=0000001 is legal R-type.
  - Adds output is_muldiv (1 bit), set for those instructions and 0 otherwise; reset value 0.
- Undefined:
  - port is_muldiv is absent.
  - opcode 0110011 with funct7=0000001 is decoded illegal (instr_type=7, writes_rd=0).

Test Plan:
- Reset asserted mid-REQ → all outputs 0 and instr_type=7 immediately; after release, completed stays 0 until enabled.
- enabled with instr_raw=0xFFF00093 (addi x1,x0,-1), pc=0x100, rf data 0xDEAD → instr_type=1, rd=1, imm=0xFFFFFFFF, rs1_val=0 (x0 forced), writes_rd=1, pc_d=0x100; completed rises after the second edge following enabled.
- instr_raw=0xFE208EE3 (beq x1,x2,-4), rf A=5, B=5 → instr_type=3, imm=0xFFFFFFFC, rs1_val=5, rs2_val=5, writes_rd=0; is_jump_predicted=1 and next_pc=0xFC pass through.
- instr_raw=0x00000000 → illegal=1, instr_type=7, imm=0, writes_rd=0, completed still asserted.
- enabled re-pulsed during CAP with a new word 0x123450B7 (lui x1) → first operation discarded; outputs reflect lui: instr_type=4, imm=0x12345000; completed drops during the enabled pulse.
- instr_raw=0x022081B3 (mul x3,x1,x2) → with DECODE_M_EXT_EN: instr_type=0, is_muldiv=1, writes_rd=1; without it: illegal=1.
